mem_responder: RTL and testbench

- Memory-side responder for the CPU core's byte-wide bus (`addr`/`dout`/`wr` from the core, `din` back to it).
- Provides a byte-addressed synchronous RAM with one-cycle read latency and a memory-mapped I/O window.
- The I/O window connects the core to host-side TX/RX byte FIFOs and a halt flag.
- Drives the core's `rdy` to stall it on TX back-pressure.

---
 rtl/mem_responder.sv | 161 ++++++++++++++++
 tb/tb_mem_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder for the CPU core's byte bus: synchronous RAM plus an I/O window
// exposing host TX/RX byte FIFOs and a sticky halt flag. Define MEM_RESP_CNT_EN to add a RAM access counter.
module mem_responder #(
  parameter int RAM_AW  = 17,
  parameter int FIFO_AW = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr_i,
  input  logic        mem_wr_i,
  input  logic [7:0]  mem_wdata_i,
  output logic [7:0]  mem_rdata_o,
  output logic        cpu_rdy_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        halt_o
);
  localparam int FDEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW + 1)'(1);

  logic       io_sel;
  logic [3:0] offset;
  logic       ram_acc, io_wr, io_rd;
  logic       tx_push, tx_pop, tx_full;
  logic       rx_push, rx_pop, rx_nonempty;
  logic       unused_addr;

  logic [7:0] ram_mem [0:(1 << RAM_AW) - 1];
  logic [7:0] ram_rd_q;
  logic [7:0] tx_mem [0:FDEPTH - 1];
  logic [7:0] rx_mem [0:FDEPTH - 1];

  logic [FIFO_AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [FIFO_AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [FIFO_AW:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic               rsel_q, rsel_d;
  logic [7:0]         io_rd_q, io_rd_d;
  logic               halt_q, halt_d;
`ifdef MEM_RESP_CNT_EN
  logic [31:0]        acc_cnt_q, acc_cnt_d;
`endif

  assign io_sel      = (mem_addr_i[17:16] == 2'b11);
  assign offset      = mem_addr_i[3:0];
  assign unused_addr = ^mem_addr_i;

  // Counts never exceed the depth, so the count MSB alone flags "full".
  assign tx_full     = tx_cnt_q[FIFO_AW];
  assign rx_nonempty = (rx_cnt_q != '0);
  assign cpu_rdy_o   = !(io_sel && mem_wr_i && (offset == 4'h0) && tx_full);

  assign ram_acc = cpu_rdy_o && !io_sel;
  assign io_wr   = cpu_rdy_o && io_sel && mem_wr_i;
  assign io_rd   = cpu_rdy_o && io_sel && !mem_wr_i;
  assign tx_push = io_wr && (offset == 4'h0);
  assign tx_pop  = tx_valid_o && tx_ready_i;
  assign rx_push = rx_valid_i && rx_ready_o;
  assign rx_pop  = io_rd && (offset == 4'h0) && rx_nonempty;

  assign tx_valid_o  = (tx_cnt_q != '0);
  assign tx_data_o   = tx_mem[tx_rp_q];
  assign rx_ready_o  = !rx_cnt_q[FIFO_AW];
  assign halt_o      = halt_q;
  assign mem_rdata_o = rsel_q ? ram_rd_q : io_rd_q;

  // Read-first RAM: a write cycle also returns the byte being overwritten.
  always_ff @(posedge clk) begin
    if (ram_acc) begin
      ram_rd_q <= ram_mem[mem_addr_i[RAM_AW-1:0]];
      if (mem_wr_i) begin
        ram_mem[mem_addr_i[RAM_AW-1:0]] <= mem_wdata_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q] <= mem_wdata_i;
    if (rx_push) rx_mem[rx_wp_q] <= rx_data_i;
  end

  always_comb begin
    tx_wp_d  = tx_push ? tx_wp_q + PTR_ONE : tx_wp_q;
    tx_rp_d  = tx_pop  ? tx_rp_q + PTR_ONE : tx_rp_q;
    tx_cnt_d = tx_cnt_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + CNT_ONE;
      2'b01:   tx_cnt_d = tx_cnt_q - CNT_ONE;
      default: tx_cnt_d = tx_cnt_q;
    endcase

    rx_wp_d  = rx_push ? rx_wp_q + PTR_ONE : rx_wp_q;
    rx_rp_d  = rx_pop  ? rx_rp_q + PTR_ONE : rx_rp_q;
    rx_cnt_d = rx_cnt_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + CNT_ONE;
      2'b01:   rx_cnt_d = rx_cnt_q - CNT_ONE;
      default: rx_cnt_d = rx_cnt_q;
    endcase

    halt_d = halt_q || (io_wr && (offset == 4'h4));

`ifdef MEM_RESP_CNT_EN
    acc_cnt_d = acc_cnt_q;
    if (io_wr && (offset == 4'h8)) acc_cnt_d = '0;
    else if (ram_acc)              acc_cnt_d = acc_cnt_q + 32'd1;
`endif

    // I/O read data is sampled from pre-edge state; stalled cycles hold the read path.
    io_rd_d = 8'h00;
    if (io_rd) begin
      case (offset)
        4'h0:    io_rd_d = rx_nonempty ? rx_mem[rx_rp_q] : 8'h00;
        4'h4:    io_rd_d = {6'b0, rx_nonempty, tx_full};
`ifdef MEM_RESP_CNT_EN
        4'h8:    io_rd_d = acc_cnt_q[7:0];
        4'h9:    io_rd_d = acc_cnt_q[15:8];
        4'hA:    io_rd_d = acc_cnt_q[23:16];
        4'hB:    io_rd_d = acc_cnt_q[31:24];
`endif
        default: io_rd_d = 8'h00;
      endcase
    end
    rsel_d = cpu_rdy_o ? !io_sel : rsel_q;
    if (!cpu_rdy_o) io_rd_d = io_rd_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      rsel_q   <= 1'b0;
      io_rd_q  <= 8'h00;
      halt_q   <= 1'b0;
`ifdef MEM_RESP_CNT_EN
      acc_cnt_q <= '0;
`endif
    end else begin
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
      rsel_q   <= rsel_d;
      io_rd_q  <= io_rd_d;
      halt_q   <= halt_d;
`ifdef MEM_RESP_CNT_EN
      acc_cnt_q <= acc_cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus pushes expected read/TX bytes, monitors pop and compare.
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr_i;
  logic        mem_wr_i;
  logic [7:0]  mem_wdata_i;
  logic [7:0]  mem_rdata_o;
  logic        cpu_rdy_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        halt_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] rd_exp[$];
  logic [7:0] tx_exp[$];
  logic rd_chk = 1'b0;
  logic pend = 1'b0;

  mem_responder dut (
    .clk(clk), .rst(rst),
    .mem_addr_i(mem_addr_i), .mem_wr_i(mem_wr_i), .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o), .cpu_rdy_o(cpu_rdy_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .halt_o(halt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: read data one cycle after an accepted checked access; TX bytes on each host pop.
  always @(negedge clk) begin
    if (pend) begin
      if (rd_exp.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rdata_unexpected: got %h expected none", mem_rdata_o);
      end else begin
        check("rdata", mem_rdata_o, rd_exp.pop_front());
      end
    end
    pend = rst && cpu_rdy_o && rd_chk;
    if (rst && tx_valid_o && tx_ready_i) begin
      if (tx_exp.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL tx_unexpected: got %h expected none", tx_data_o);
      end else begin
        check("tx_data", tx_data_o, tx_exp.pop_front());
      end
    end
  end

  task automatic cpu_access(input logic [31:0] a, input logic w, input logic [7:0] d,
                            input logic c, input logic [7:0] e);
    @(posedge clk); #1;
    mem_addr_i = a; mem_wr_i = w; mem_wdata_i = d; rd_chk = c; rx_valid_i = 1'b0;
    if (c) rd_exp.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) cpu_access(32'h0003_000F, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic host_push(input logic [7:0] d);
    idle(1);
    rx_valid_i = 1'b1; rx_data_i = d;
  endtask

  initial begin
    int k;
    rst = 1'b0; mem_addr_i = 32'h0003_000F; mem_wr_i = 1'b0; mem_wdata_i = 8'h00;
    tx_ready_i = 1'b0; rx_data_i = 8'h00; rx_valid_i = 1'b0;
    #1;
    check("rst_rdata", mem_rdata_o, 8'h00);
    check("rst_halt", halt_o, 1'b0);
    check("rst_tx_valid", tx_valid_o, 1'b0);
    check("rst_rx_ready", rx_ready_o, 1'b1);
    check("rst_cpu_rdy", cpu_rdy_o, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // RAM round trip, read-during-write, address aliasing
    cpu_access(32'h0000_0010, 1'b1, 8'hA5, 1'b0, 8'h00);
    cpu_access(32'h0000_0010, 1'b0, 8'h00, 1'b1, 8'hA5);
    cpu_access(32'h0000_0010, 1'b1, 8'h3C, 1'b1, 8'hA5);
    cpu_access(32'h0000_0010, 1'b0, 8'h00, 1'b1, 8'h3C);
    cpu_access(32'hFFF2_0010, 1'b0, 8'h00, 1'b1, 8'h3C);
    cpu_access(32'h0001_FFFF, 1'b1, 8'h5E, 1'b0, 8'h00);
    cpu_access(32'h0001_FFFF, 1'b0, 8'h00, 1'b1, 8'h5E);
    cpu_access(32'h0003_000C, 1'b1, 8'h12, 1'b0, 8'h00);
    cpu_access(32'h0003_000C, 1'b0, 8'h00, 1'b1, 8'h00);

    // TX fill, status, stall with held read data, release after first pop
    for (int i = 0; i < 8; i++) begin
      cpu_access(32'h0003_0000, 1'b1, 8'(8'h41 + i), 1'b0, 8'h00);
      tx_exp.push_back(8'(8'h41 + i));
      @(negedge clk);
      check("tx_fill_rdy", cpu_rdy_o, 1'b1);
    end
    cpu_access(32'h0003_0004, 1'b0, 8'h00, 1'b1, 8'h01);
    cpu_access(32'h0000_0010, 1'b0, 8'h00, 1'b1, 8'h3C);
    cpu_access(32'h0003_0000, 1'b1, 8'h49, 1'b0, 8'h00);
    tx_exp.push_back(8'h49);
    @(negedge clk);
    check("tx_stall_rdy", cpu_rdy_o, 1'b0);
    check("tx_valid_full", tx_valid_o, 1'b1);
    @(negedge clk);
    check("stall_rdata_hold", mem_rdata_o, 8'h3C);
    @(posedge clk); #1 tx_ready_i = 1'b1;
    @(negedge clk);
    check("pop_cycle_still_stalled", cpu_rdy_o, 1'b0);
    @(negedge clk);
    check("rdy_after_pop", cpu_rdy_o, 1'b1);
    k = 0;
    while (tx_exp.size() != 0 && k < 40) begin
      idle(1);
      k++;
    end
    idle(2);
    check("tx_drained", tx_exp.size(), 0);
    @(negedge clk);
    check("tx_valid_empty", tx_valid_o, 1'b0);
    tx_ready_i = 1'b0;

    // RX path and status
    host_push(8'h5A);
    cpu_access(32'h0003_0004, 1'b0, 8'h00, 1'b1, 8'h02);
    cpu_access(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h5A);
    cpu_access(32'h0003_0004, 1'b0, 8'h00, 1'b1, 8'h00);

    // RX underflow, fill, overflow rejection
    cpu_access(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h00);
    cpu_access(32'h0003_0004, 1'b0, 8'h00, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++) host_push(8'(8'h10 + i));
    host_push(8'h99);
    @(negedge clk);
    check("rx_ready_full", rx_ready_o, 1'b0);
    idle(1);
    for (int i = 0; i < 8; i++) cpu_access(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'(8'h10 + i));
    cpu_access(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h00);
    @(negedge clk);
    check("rx_ready_empty", rx_ready_o, 1'b1);

    // Simultaneous push with empty pop, and with non-empty pop
    cpu_access(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h00);
    rx_valid_i = 1'b1; rx_data_i = 8'h77;
    cpu_access(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h77);
    host_push(8'h61);
    cpu_access(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h61);
    rx_valid_i = 1'b1; rx_data_i = 8'h62;
    cpu_access(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h62);
    cpu_access(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h00);

    // Halt is sticky
    cpu_access(32'h0003_0004, 1'b1, 8'hEE, 1'b0, 8'h00);
    @(negedge clk);
    check("halt_not_yet", halt_o, 1'b0);
    idle(1);
    @(negedge clk);
    check("halt_set", halt_o, 1'b1);
    idle(3);
    @(negedge clk);
    check("halt_sticky", halt_o, 1'b1);

    // Asynchronous reset mid TX burst
    for (int i = 0; i < 3; i++) cpu_access(32'h0003_0000, 1'b1, 8'(8'hC0 + i), 1'b0, 8'h00);
    host_push(8'h33);
    cpu_access(32'h0000_0010, 1'b0, 8'h00, 1'b1, 8'h3C);
    idle(1);
    @(negedge clk);
    check("pre_rst_tx_valid", tx_valid_o, 1'b1);
    check("pre_rst_rdata", mem_rdata_o, 8'h3C);
    #2 rst = 1'b0;
    #1;
    check("arst_halt", halt_o, 1'b0);
    check("arst_tx_valid", tx_valid_o, 1'b0);
    check("arst_rdata", mem_rdata_o, 8'h00);
    check("arst_rx_ready", rx_ready_o, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    cpu_access(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h00);
    cpu_access(32'h0000_0010, 1'b0, 8'h00, 1'b1, 8'h3C);

`ifdef MEM_RESP_CNT_EN
    cpu_access(32'h0003_0008, 1'b1, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) cpu_access(32'h0000_0010, 1'b0, 8'h00, 1'b1, 8'h3C);
    for (int i = 0; i < 3; i++) cpu_access(32'h0000_0100 + i, 1'b1, 8'(i), 1'b0, 8'h00);
    cpu_access(32'h0003_0004, 1'b0, 8'h00, 1'b1, 8'h00);
    cpu_access(32'h0003_000F, 1'b1, 8'h00, 1'b0, 8'h00);
    cpu_access(32'h0003_0008, 1'b0, 8'h00, 1'b1, 8'h08);
    cpu_access(32'h0003_0009, 1'b0, 8'h00, 1'b1, 8'h00);
    cpu_access(32'h0003_000A, 1'b0, 8'h00, 1'b1, 8'h00);
    cpu_access(32'h0003_000B, 1'b0, 8'h00, 1'b1, 8'h00);
    cpu_access(32'h0003_0008, 1'b1, 8'h55, 1'b0, 8'h00);
    cpu_access(32'h0003_0008, 1'b0, 8'h00, 1'b1, 8'h00);
`else
    cpu_access(32'h0000_0010, 1'b0, 8'h00, 1'b1, 8'h3C);
    cpu_access(32'h0003_0008, 1'b0, 8'h00, 1'b1, 8'h00);
    cpu_access(32'h0003_000B, 1'b0, 8'h00, 1'b1, 8'h00);
`endif

    idle(3);
    @(negedge clk);
    check("rd_queue_empty", rd_exp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
